// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
// MOUSE_WHEEL_EN adds the fourth (wheel) packet byte state.
package mouse_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_B0,
      S_B1,
      S_B2,
`ifdef MOUSE_WHEEL_EN
      S_B3,
`endif
      S_UPDATE
   } state_t;

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;
   localparam int ALIGN = 3;
   localparam int XS    = 4;
   localparam int YS    = 5;
   localparam int XO    = 6;
   localparam int YO    = 7;

   localparam int DEF_X_MAX = 159;
   localparam int DEF_Y_MAX = 119;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// One cursor axis: overflow saturation of the 9-bit delta, add (or
// subtract when NEGATE) in 11-bit signed, then clamp to [0, MAX].
module mouse_axis_clamp #(
   parameter int MAX    = 255,
   parameter bit NEGATE = 1'b0
) (
   input  logic [7:0] pos_i,
   input  logic       sign_i,
   input  logic       ovf_i,
   input  logic [7:0] mag_i,
   output logic [8:0] delta_o,
   output logic [7:0] pos_o
);

   logic signed [10:0] step;
   logic signed [10:0] base;
   logic signed [10:0] sum;

   always_comb begin
      delta_o = {sign_i, mag_i};
      if (ovf_i) delta_o = sign_i ? 9'h100 : 9'h0FF;
      step = $signed({{2{delta_o[8]}}, delta_o});
      base = $signed({3'b000, pos_i});
      sum  = NEGATE ? (base - step) : (base + step);
      if (sum < 11'sd0) pos_o = 8'd0;
      else if (sum > $signed(11'(MAX))) pos_o = 8'(MAX);
      else pos_o = sum[7:0];
   end

endmodule

// File: rtl/mouse_packet_decoder.sv
// Collects PS/2 mouse bytes into packets and tracks a clamped cursor.
// Define MOUSE_WHEEL_EN for 4-byte wheel packets (MOUSE_DZ live).
module mouse_packet_decoder
   import mouse_pkg::*;
#(
   parameter int X_MAX          = DEF_X_MAX,
   parameter int Y_MAX          = DEF_Y_MAX,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic       READ_ENABLE,
   output logic [7:0] MOUSE_STATUS,
   output logic [8:0] MOUSE_DX,
   output logic [8:0] MOUSE_DY,
   output logic [3:0] MOUSE_DZ,
   output logic [7:0] MOUSE_X,
   output logic [7:0] MOUSE_Y,
   output logic       PACKET_VALID,
   output logic [7:0] ERR_CNT
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    err_q;
   logic [7:0]    status_q, x_q, y_q;
   logic [8:0]    dx_q, dy_q;
   logic          re_q, pv_q;
   logic          drop;
   logic          byte_bad;
   logic [8:0]    dx_w, dy_w;
   logic [7:0]    x_w, y_w;
`ifdef MOUSE_WHEEL_EN
   logic [3:0]    b3_q, b3_d, dz_q;
`endif

   always_comb begin
      state_d  = state_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      b2_d     = b2_q;
`ifdef MOUSE_WHEEL_EN
      b3_d     = b3_q;
`endif
      tmo_d    = '0;
      drop     = 1'b0;
      byte_bad = BYTE_ERROR_CODE != 2'b00;
      unique case (state_q)
         S_IDLE: if (ENABLE) state_d = S_B0;
         // a byte arriving during S_UPDATE already starts the next packet
         S_B0, S_UPDATE: begin
            state_d = S_B0;
            if (BYTE_READY) begin
               if (byte_bad || !BYTE_READ[ALIGN]) begin
                  drop = 1'b1;
               end else begin
                  b0_d    = BYTE_READ;
                  state_d = S_B1;
               end
            end
         end
         default: begin
            if (BYTE_READY && byte_bad) begin
               drop    = 1'b1;
               state_d = S_B0;
            end else if (BYTE_READY) begin
               unique case (state_q)
                  S_B1: begin
                     b1_d    = BYTE_READ;
                     state_d = S_B2;
                  end
`ifdef MOUSE_WHEEL_EN
                  S_B2: begin
                     b2_d    = BYTE_READ;
                     state_d = S_B3;
                  end
                  default: begin
                     b3_d    = BYTE_READ[3:0];
                     state_d = S_UPDATE;
                  end
`else
                  default: begin
                     b2_d    = BYTE_READ;
                     state_d = S_UPDATE;
                  end
`endif
               endcase
            end else if (tmo_q == TMO_LAST) begin
               drop    = 1'b1;
               state_d = S_B0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
      endcase
      if (!ENABLE) begin
         state_d = S_IDLE;
         drop    = 1'b0;
      end
   end

   mouse_axis_clamp #(.MAX(X_MAX), .NEGATE(1'b0)) u_x (
      .pos_i   (x_q),
      .sign_i  (b0_q[XS]),
      .ovf_i   (b0_q[XO]),
      .mag_i   (b1_q),
      .delta_o (dx_w),
      .pos_o   (x_w)
   );

   mouse_axis_clamp #(.MAX(Y_MAX), .NEGATE(1'b1)) u_y (
      .pos_i   (y_q),
      .sign_i  (b0_q[YS]),
      .ovf_i   (b0_q[YO]),
      .mag_i   (b2_q),
      .delta_o (dy_w),
      .pos_o   (y_w)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_IDLE;
         b0_q     <= '0;
         b1_q     <= '0;
         b2_q     <= '0;
         tmo_q    <= '0;
         err_q    <= '0;
         status_q <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         x_q      <= 8'(X_MAX / 2);
         y_q      <= 8'(Y_MAX / 2);
         re_q     <= 1'b0;
         pv_q     <= 1'b0;
`ifdef MOUSE_WHEEL_EN
         b3_q     <= '0;
         dz_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         tmo_q   <= tmo_d;
         if (drop) err_q <= sat_inc(err_q);
         re_q    <= state_d != S_IDLE;
         pv_q    <= state_q == S_UPDATE;
`ifdef MOUSE_WHEEL_EN
         b3_q    <= b3_d;
`endif
         if (state_q == S_UPDATE) begin
            status_q <= b0_q;
            dx_q     <= dx_w;
            dy_q     <= dy_w;
            x_q      <= x_w;
            y_q      <= y_w;
`ifdef MOUSE_WHEEL_EN
            dz_q     <= b3_q;
`endif
         end
      end
   end

   assign READ_ENABLE  = re_q;
   assign MOUSE_STATUS = status_q;
   assign MOUSE_DX     = dx_q;
   assign MOUSE_DY     = dy_q;
   assign MOUSE_X      = x_q;
   assign MOUSE_Y      = y_q;
   assign PACKET_VALID = pv_q;
   assign ERR_CNT      = err_q;
`ifdef MOUSE_WHEEL_EN
   assign MOUSE_DZ     = dz_q;
`else
   assign MOUSE_DZ     = 4'd0;
`endif

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Scoreboard bench for mouse_packet_decoder with a packet-level model.
// Honours MOUSE_WHEEL_EN for 4-byte packets.
module tb_mouse_packet_decoder;

   localparam int XM = 159;
   localparam int YM = 119;
   localparam int T  = 40;
`ifdef MOUSE_WHEEL_EN
   localparam int NB = 4;
`else
   localparam int NB = 3;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENABLE = 1'b0;
   logic [7:0] BYTE_READ = 8'd0;
   logic [1:0] BYTE_ERROR_CODE = 2'd0;
   logic       BYTE_READY = 1'b0;
   logic       READ_ENABLE;
   logic [7:0] MOUSE_STATUS;
   logic [8:0] MOUSE_DX;
   logic [8:0] MOUSE_DY;
   logic [3:0] MOUSE_DZ;
   logic [7:0] MOUSE_X;
   logic [7:0] MOUSE_Y;
   logic       PACKET_VALID;
   logic [7:0] ERR_CNT;

   mouse_packet_decoder #(
      .X_MAX(XM), .Y_MAX(YM), .TIMEOUT_CYCLES(T)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
      .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
      .BYTE_READY(BYTE_READY), .READ_ENABLE(READ_ENABLE),
      .MOUSE_STATUS(MOUSE_STATUS), .MOUSE_DX(MOUSE_DX),
      .MOUSE_DY(MOUSE_DY), .MOUSE_DZ(MOUSE_DZ),
      .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y),
      .PACKET_VALID(PACKET_VALID), .ERR_CNT(ERR_CNT)
   );

   always #5 CLK = ~CLK;

   int cyc_n = 0;
   always @(posedge CLK) cyc_n <= cyc_n + 1;

   typedef struct {
      int st, dx, dy, dz, x, y, at;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] pkt[$];
   int         x_m, y_m, errs_m, gap;
   int         checks = 0;
   int         failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic int delta(input logic [7:0] b0, input logic [7:0] m,
                                input int si, input int oi);
      if (b0[oi]) return b0[si] ? -256 : 255;
      return int'(m) - (b0[si] ? 256 : 0);
   endfunction

   function automatic void err_inc();
      if (errs_m < 255) errs_m++;
   endfunction

   function automatic void finish_pkt();
      exp_t e;
      e.st = int'(pkt[0]);
      e.dx = delta(pkt[0], pkt[1], 4, 6);
      e.dy = delta(pkt[0], pkt[2], 5, 7);
`ifdef MOUSE_WHEEL_EN
      e.dz = int'($signed(pkt[3][3:0]));
`else
      e.dz = 0;
`endif
      x_m  = clampi(x_m + e.dx, XM);
      y_m  = clampi(y_m - e.dy, YM);
      e.x  = x_m;
      e.y  = y_m;
      e.at = cyc_n + 2;
      sb.push_back(e);
      pkt.delete();
   endfunction

   function automatic void model_byte(input logic [7:0] b, input logic [1:0] e);
      if (pkt.size() == 0) begin
         if (e != 2'd0 || !b[3]) err_inc();
         else pkt.push_back(b);
      end else if (e != 2'd0) begin
         err_inc();
         pkt.delete();
      end else begin
         pkt.push_back(b);
         if (pkt.size() == NB) finish_pkt();
      end
   endfunction

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         gap++;
         if (gap == T && pkt.size() != 0) begin
            err_inc();
            pkt.delete();
         end
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [1:0] e);
      BYTE_READ       = b;
      BYTE_ERROR_CODE = e;
      BYTE_READY      = 1'b1;
      model_byte(b, e);
      cyc();
      BYTE_READY      = 1'b0;
      BYTE_ERROR_CODE = 2'd0;
      gap             = 0;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
      send(a, 2'd0);
      send(b, 2'd0);
      send(c, 2'd0);
`ifdef MOUSE_WHEEL_EN
      send(8'h00, 2'd0);
`endif
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      cyc();
      x_m = XM / 2;
      y_m = YM / 2;
      errs_m = 0;
      gap = 0;
      pkt.delete();
      check("rst_re", int'(READ_ENABLE), 0);
      check("rst_pv", int'(PACKET_VALID), 0);
      check("rst_err", int'(ERR_CNT), 0);
      check("rst_x", int'(MOUSE_X), XM / 2);
      check("rst_y", int'(MOUSE_Y), YM / 2);
      check("rst_st", int'(MOUSE_STATUS), 0);
      check("rst_dx", int'(MOUSE_DX), 0);
      check("rst_dy", int'(MOUSE_DY), 0);
      check("rst_dz", int'(MOUSE_DZ), 0);
      RESET = 1'b0;
      cyc();
   endtask

   task automatic drop_enable();
      ENABLE = 1'b0;
      cyc();
      pkt.delete();
      check("re_off", int'(READ_ENABLE), 0);
      check("drop_err", int'(ERR_CNT), errs_m);
      cyc();
      ENABLE = 1'b1;
      cyc();
      cyc();
      check("re_on", int'(READ_ENABLE), 1);
      gap = 0;
   endtask

   always @(negedge CLK) begin
      if (sb.size() != 0 && (PACKET_VALID || cyc_n >= sb[0].at)) begin
         mon_e = sb.pop_front();
         check("pv_cycle", PACKET_VALID ? cyc_n : -1, mon_e.at);
         check("status", int'(MOUSE_STATUS), mon_e.st);
         check("dx", int'($signed(MOUSE_DX)), mon_e.dx);
         check("dy", int'($signed(MOUSE_DY)), mon_e.dy);
         check("dz", int'($signed(MOUSE_DZ)), mon_e.dz);
         check("x", int'(MOUSE_X), mon_e.x);
         check("y", int'(MOUSE_Y), mon_e.y);
      end else if (PACKET_VALID) begin
         check("pv_spurious", int'(PACKET_VALID), 0);
      end
   end

   initial begin
      logic [7:0] b;
      logic [1:0] e;
      int r;
      do_reset();
      ENABLE = 1'b1;
      cyc();
      check("re_on0", int'(READ_ENABLE), 1);

      send3(8'h08, 8'h05, 8'h03);
      idle(3);
      check("tp_x84", int'(MOUSE_X), 84);
      check("tp_y56", int'(MOUSE_Y), 56);

      send3(8'h18, 8'hB1, 8'h00);
      send3(8'h18, 8'hF0, 8'h00);
      idle(3);
      check("clamp_lo", int'(MOUSE_X), 0);
      send3(8'h48, 8'h10, 8'h00);
      idle(3);
      check("clamp_hi", int'(MOUSE_X), XM);
      check("ovf_dx", int'($signed(MOUSE_DX)), 255);

      send(8'h00, 2'd0);
      check("misalign_err", int'(ERR_CNT), errs_m);
      send3(8'h09, 8'h01, 8'h01);
      idle(3);
      check("resync_st", int'(MOUSE_STATUS), 9);

      send(8'h08, 2'd0);
      send(8'h01, 2'd1);
      check("byteerr_err", int'(ERR_CNT), errs_m);
      idle(3);
      send3(8'h08, 8'h02, 8'h02);
      idle(3);

      send(8'h08, 2'd0);
      idle(T);
      check("timeout_err", int'(ERR_CNT), errs_m);
      send3(8'h28, 8'h03, 8'hFE);
      idle(3);

      send(8'h08, 2'd0);
      send(8'h12, 2'd0);
      drop_enable();

`ifdef MOUSE_WHEEL_EN
      send(8'h08, 2'd0);
      send(8'h00, 2'd0);
      send(8'h00, 2'd0);
      send(8'h0F, 2'd0);
      idle(3);
      check("wheel_dz", int'($signed(MOUSE_DZ)), -1);
      check("wheel_x", int'(MOUSE_X), x_m);
`endif

      send(8'h08, 2'd0);
      do_reset();

      for (int i = 0; i < 260; i++) send(8'h00, 2'd0);
      check("err_sat", int'(ERR_CNT), errs_m);
      do_reset();

      for (int i = 0; i < 400; i++) begin
         b = 8'($urandom);
         if (pkt.size() == 0 && $urandom_range(0, 3) != 0) b[3] = 1'b1;
         e = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         send(b, e);
         r = $urandom_range(0, 19);
         if (r < 14) idle($urandom_range(0, 2));
         else if (r < 16) idle(T - 1);
         else if (r < 17) idle(T);
         else if (r < 18) idle(T + 3);
         else if (pkt.size() != 0) drop_enable();
         else idle(1);
      end

      idle(5);
      check("sb_drained", sb.size(), 0);
      check("final_err", int'(ERR_CNT), errs_m);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mouse_packet_decoder.md
# mouse_packet_decoder

Downstream consumer of the PS/2 byte receiver. It gates the receiver with READ_ENABLE and collects its bytes into 3-byte mouse packets, resynchronising on framing or byte errors. It decodes button status and signed 9-bit deltas, and accumulates them into a clamped screen-space cursor position for the bus-side mouse peripheral.

## Interface
Parameters:
- X_MAX, 159: largest X coordinate (≤255)
- Y_MAX, 119: largest Y coordinate (≤255)
- TIMEOUT_CYCLES, 2_000_000: idle cycles allowed between bytes of one packet (20 ms @ 100 MHz)

Ports:
- CLK  in  1  system clock; one clock domain
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  decoding allowed; from the init controller once stream mode is on
- BYTE_READ  in  8  byte from receiver
- BYTE_ERROR_CODE  in  2  receiver error flags; nonzero = bad byte
- BYTE_READY  in  1  one-cycle strobe; BYTE_READ is valid in the same cycle
- READ_ENABLE  out  1  enables the receiver
- MOUSE_STATUS  out  8  byte 0 of the last good packet
- MOUSE_DX, MOUSE_DY  out  9 each  signed deltas of the last good packet
- MOUSE_DZ  out  4  signed wheel delta; 0 when wheel support is compiled out
- MOUSE_X, MOUSE_Y  out  8 each  clamped cursor position
- PACKET_VALID  out  1  one-cycle pulse when outputs update
- ERR_CNT  out  8  saturating count of discarded packets

## Operation
- Reset values:
  - READ_ENABLE=0, PACKET_VALID=0, ERR_CNT=0.
  - STATUS, DX, DY and DZ are 0.
  - MOUSE_X=X_MAX/2 (integer division) and MOUSE_Y=Y_MAX/2.
  - State is S_IDLE.
- States: S_IDLE, S_B0, S_B1, S_B2, (S_B3 when the wheel is enabled), S_UPDATE.
- S_IDLE: READ_ENABLE=0. When ENABLE=1, go to S_B0. READ_ENABLE=1 in every other state.
- S_B0, on BYTE_READY:
  - If the error code is nonzero or BYTE_READ[3]=0, it is a misaligned byte. Discard it, increment ERR_CNT and stay in S_B0.
  - Otherwise store the byte and go to S_B1.
- S_B1 and S_B2 (and S_B3), on BYTE_READY:
  - Nonzero error code: discard the partial packet, increment ERR_CNT and go to S_B0.
  - Otherwise store the byte and advance. The last byte goes to S_UPDATE.
- Timeout:
  - An inter-byte counter is cleared on every BYTE_READY and on entry to S_B0.
  - In S_B1, S_B2 and S_B3 it counts; on reaching TIMEOUT_CYCLES-1 the packet is discarded, ERR_CNT increments and the state goes to S_B0.
  - The counter never counts in S_B0.
- S_UPDATE (one cycle), decoding:
  - DX={B0[4],B1} and DY={B0[5],B2}.
  - If B0[6] (X overflow) is set, DX saturates to −256 when B0[4]=1, otherwise to +255. B0[7] does the same for DY.
- S_UPDATE, position update:
  - X_new=X+DX and Y_new=Y−DY, because screen Y grows downward.
  - Compute in 11-bit signed arithmetic, then clamp to [0,X_MAX] and [0,Y_MAX].
- S_UPDATE then returns to S_B0.
- A BYTE_READY seen in the S_UPDATE cycle is processed as the S_B0 byte of the next packet.
- ENABLE=0 in any state: go to S_IDLE next cycle and drop the partial packet. Positions and ERR_CNT hold, with no error counted.
- RESET mid-packet: full reset to the reset values above, including position.
- ERR_CNT saturates at 255.

## Timing
- Last packet byte has BYTE_READY high in cycle N. The state is S_UPDATE in cycle N+1.
- In cycle N+2, all outputs show the new values and PACKET_VALID=1 for exactly one cycle.
- All outputs are registered; there is no combinational path from input to output.
- READ_ENABLE deasserts in the cycle after ENABLE falls.

## Configuration
- MOUSE_WHEEL_EN defined: 4-byte packets; S_B3 exists.
  - MOUSE_DZ = B3[3:0].
  - The timeout also applies between byte 2 and byte 3.
- MOUSE_WHEEL_EN undefined: 3-byte packets; S_B3 is absent and MOUSE_DZ is tied to 0.

## Structure
- Package mouse_pkg holds:
  - the state enum;
  - B0 bit-index constants (BTN_L=0, BTN_R=1, BTN_M=2, ALIGN=3, XS=4, YS=5, XO=6, YO=7);
  - the default X_MAX and Y_MAX.
- Sub-module mouse_axis_clamp does delta saturation, add and clamp for one axis. It is parameterised by MAX and by a NEGATE flag, and is instantiated once per axis.

## Test plan
- Packet 0x08,0x05,0x03 from reset: DX=+5, DY=+3, X=84, Y=56; PACKET_VALID 2 cycles after the third BYTE_READY.
- Packet 0x18,0xF0,0x00 with X=5: DX=−16 and X clamps to 0. Packet 0x48,0x10,0x00: DX=+255 and X clamps to 159.
- Byte stream 0x00 (bit3=0), then 0x09,0x01,0x01: ERR_CNT=1, then a good packet with STATUS=0x09.
- Byte 0x08, then BYTE_ERROR_CODE=2'b01 on byte 1: ERR_CNT increments, no PACKET_VALID, next valid packet decodes normally.
- Byte 0x08, then TIMEOUT_CYCLES idle cycles: ERR_CNT=1, state S_B0. ENABLE dropped mid-packet: READ_ENABLE=0 next cycle, ERR_CNT unchanged.
- With MOUSE_WHEEL_EN, packet 0x08,0x00,0x00,0x0F: MOUSE_DZ=4'hF (−1), X and Y unchanged.
